// File: rtl/sc_speedsched_pkg.sv
// rtl/sc_speedsched_pkg.sv - shared state encoding, default timing constants and period clamp
package sc_speedsched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CLEAR   = 2'b01,
        ST_RUN     = 2'b10,
        ST_LEVELUP = 2'b11
    } state_t;

    localparam int DEF_MAX_LEVEL   = 9;
    localparam int DEF_BASE_PERIOD = 25000000;
    localparam int DEF_PERIOD_STEP = 2000000;
    localparam int DEF_MIN_PERIOD  = 5000000;

    // Wide operands so the subtraction can never wrap below the floor.
    function automatic logic [63:0] clamp_period(
        input logic [63:0] base_period,
        input logic [63:0] min_period,
        input logic [63:0] product
    );
        if (product > (base_period - min_period)) begin
            return min_period;
        end
        return base_period - product;
    endfunction

endpackage

// File: rtl/sc_speedsched_ticktimer.sv
// rtl/sc_speedsched_ticktimer.sv - free-running period timer emitting a registered one-cycle tick
module sc_speedsched_ticktimer #(
    parameter int TIMER_WIDTH = 25
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [TIMER_WIDTH-1:0] i_period,
    input  logic                   i_clear,
    input  logic                   i_enable,
    input  logic                   i_hold,
    output logic                   o_tick
);

    logic [TIMER_WIDTH-1:0] r_timer;
    logic                   r_tick;
    logic [TIMER_WIDTH-1:0] w_last;

    assign w_last = i_period - TIMER_WIDTH'(1);

    // ">=" also catches a timer left beyond a period that shrank underneath it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer <= '0;
            r_tick  <= 1'b0;
        end else if (i_clear || !i_enable) begin
            r_timer <= '0;
            r_tick  <= 1'b0;
        end else if (i_hold) begin
            r_tick  <= 1'b0;
        end else if (r_timer >= w_last) begin
            r_timer <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_timer <= r_timer + TIMER_WIDTH'(1);
            r_tick  <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/sc_speed_scheduler.sv
// rtl/sc_speed_scheduler.sv - game-level sequencer driving the speed counter and lane-move tick
module sc_speed_scheduler
    import sc_speedsched_pkg::*;
#(
    parameter int LEVEL_WIDTH = 4,
    parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int TIMER_WIDTH = 25,
    parameter int BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int PERIOD_STEP = DEF_PERIOD_STEP,
    parameter int MIN_PERIOD  = DEF_MIN_PERIOD
) (
    input  logic                   SC_SPEEDSCHED_CLOCK_50,
    input  logic                   SC_SPEEDSCHED_RESET_InHigh,
    input  logic                   SC_SPEEDSCHED_start_InLow,
    input  logic                   SC_SPEEDSCHED_levelup_InLow,
    input  logic                   SC_SPEEDSCHED_gameover_InLow,
    input  logic                   SC_SPEEDSCHED_hold_InLow,
    input  logic [LEVEL_WIDTH-1:0] SC_SPEEDSCHED_level_InBUS,
    output logic                   SC_SPEEDSCHED_upcount_OutLow,
    output logic                   SC_SPEEDSCHED_T0_OutLow,
    output logic                   SC_SPEEDSCHED_tick_OutHigh,
    output logic                   SC_SPEEDSCHED_maxlevel_OutHigh,
    output logic [1:0]             SC_SPEEDSCHED_state_OutBUS
);

    localparam int                     PROD_WIDTH   = TIMER_WIDTH + LEVEL_WIDTH;
    localparam logic [LEVEL_WIDTH-1:0] LP_MAX_LEVEL = LEVEL_WIDTH'(MAX_LEVEL);

    state_t r_state;
    state_t w_state_next;
    logic   r_start_d;
    logic   r_levelup_d;
    logic   r_maxlevel;

    logic                   w_start_evt;
    logic                   w_levelup_evt;
    logic                   w_below_max;
    logic [LEVEL_WIDTH-1:0] w_level_sat;
    logic [PROD_WIDTH-1:0]  w_product;
    logic [TIMER_WIDTH-1:0] w_period;
    logic                   w_timer_clear;
    logic                   w_timer_enable;

    assign w_start_evt   = r_start_d & ~SC_SPEEDSCHED_start_InLow;
    assign w_levelup_evt = r_levelup_d & ~SC_SPEEDSCHED_levelup_InLow;
    assign w_below_max   = (SC_SPEEDSCHED_level_InBUS < LP_MAX_LEVEL);

    assign w_level_sat = (SC_SPEEDSCHED_level_InBUS > LP_MAX_LEVEL) ? LP_MAX_LEVEL
                                                                   : SC_SPEEDSCHED_level_InBUS;
    assign w_product   = PROD_WIDTH'(w_level_sat) * PROD_WIDTH'(PERIOD_STEP);
    assign w_period    = TIMER_WIDTH'(clamp_period(64'(BASE_PERIOD), 64'(MIN_PERIOD),
                                                   64'(w_product)));

    always_ff @(posedge SC_SPEEDSCHED_CLOCK_50) begin
        if (SC_SPEEDSCHED_RESET_InHigh) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b1;
            r_levelup_d <= 1'b1;
            r_maxlevel  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_start_d   <= SC_SPEEDSCHED_start_InLow;
            r_levelup_d <= SC_SPEEDSCHED_levelup_InLow;
            r_maxlevel  <= (SC_SPEEDSCHED_level_InBUS >= LP_MAX_LEVEL);
        end
    end

    // Gameover outranks levelup; a levelup edge seen outside RUN is lost.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_evt) w_state_next = ST_CLEAR;
            ST_CLEAR:   w_state_next = ST_RUN;
            ST_RUN: begin
                if (!SC_SPEEDSCHED_gameover_InLow) begin
                    w_state_next = ST_IDLE;
                end else if (w_levelup_evt && w_below_max) begin
                    w_state_next = ST_LEVELUP;
                end
            end
            ST_LEVELUP: w_state_next = ST_RUN;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    assign w_timer_clear  = (r_state == ST_CLEAR) || (r_state == ST_LEVELUP);
    assign w_timer_enable = (r_state == ST_RUN);

    sc_speedsched_ticktimer #(
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_ticktimer (
        .i_clk    (SC_SPEEDSCHED_CLOCK_50),
        .i_rst    (SC_SPEEDSCHED_RESET_InHigh),
        .i_period (w_period),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_enable),
        .i_hold   (~SC_SPEEDSCHED_hold_InLow),
        .o_tick   (SC_SPEEDSCHED_tick_OutHigh)
    );

    assign SC_SPEEDSCHED_T0_OutLow        = (r_state != ST_CLEAR);
    assign SC_SPEEDSCHED_upcount_OutLow   = (r_state != ST_LEVELUP);
    assign SC_SPEEDSCHED_maxlevel_OutHigh = r_maxlevel;
    assign SC_SPEEDSCHED_state_OutBUS     = r_state;

endmodule

// File: tb/tb_sc_speed_scheduler.sv
// tb/tb_sc_speed_scheduler.sv - directed and randomized bench for sc_speed_scheduler with a level-counter stand-in
module tb_sc_speed_scheduler;

    localparam int BASE = 10;
    localparam int STEP = 2;
    localparam int MINP = 5;
    localparam int MAXL = 3;
    localparam int TW   = 8;
    localparam int LW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_n = 1'b1;
    logic          lvl_n = 1'b1;
    logic          go_n = 1'b1;
    logic          hold_n = 1'b1;
    logic [LW-1:0] lvl_cnt = '0;
    logic          up_n;
    logic          t0_n;
    logic          tick;
    logic          maxlvl;
    logic [1:0]    state;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int n_up    = 0;
    int n_tick  = 0;

    always #5 clk = ~clk;

    sc_speed_scheduler #(
        .LEVEL_WIDTH(LW), .MAX_LEVEL(MAXL), .TIMER_WIDTH(TW),
        .BASE_PERIOD(BASE), .PERIOD_STEP(STEP), .MIN_PERIOD(MINP)
    ) dut (
        .SC_SPEEDSCHED_CLOCK_50        (clk),
        .SC_SPEEDSCHED_RESET_InHigh    (rst),
        .SC_SPEEDSCHED_start_InLow     (start_n),
        .SC_SPEEDSCHED_levelup_InLow   (lvl_n),
        .SC_SPEEDSCHED_gameover_InLow  (go_n),
        .SC_SPEEDSCHED_hold_InLow      (hold_n),
        .SC_SPEEDSCHED_level_InBUS     (lvl_cnt),
        .SC_SPEEDSCHED_upcount_OutLow  (up_n),
        .SC_SPEEDSCHED_T0_OutLow       (t0_n),
        .SC_SPEEDSCHED_tick_OutHigh    (tick),
        .SC_SPEEDSCHED_maxlevel_OutHigh(maxlvl),
        .SC_SPEEDSCHED_state_OutBUS    (state)
    );

    // Stand-in for the external speed counter: clear on T0, count on upcount.
    always @(posedge clk) begin
        if (rst)        lvl_cnt <= '0;
        else if (!t0_n) lvl_cnt <= '0;
        else if (!up_n) lvl_cnt <= lvl_cnt + 1'b1;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Reference: game phase (spec codes), counting cycles accumulated toward the next tick.
    int            m_phase = 0;
    int            m_cnt   = 0;
    logic          m_tick  = 1'b0;
    logic          m_max   = 1'b0;
    logic [LW-1:0] m_level = '0;
    logic          m_ps    = 1'b1;
    logic          m_pl    = 1'b1;

    function automatic int period_of(input logic [LW-1:0] lv);
        int l = (int'(lv) > MAXL) ? MAXL : int'(lv);
        int p = BASE - l * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_cnt <= 0; m_tick <= 1'b0; m_max <= 1'b0;
            m_level <= '0; m_ps <= 1'b1; m_pl <= 1'b1;
        end else begin
            m_ps  <= start_n;
            m_pl  <= lvl_n;
            m_max <= (int'(m_level) >= MAXL);
            if (m_phase == 2 && hold_n) begin
                if (m_cnt + 1 >= period_of(m_level)) begin
                    m_cnt <= 0; m_tick <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1; m_tick <= 1'b0;
                end
            end else begin
                m_tick <= 1'b0;
                if (m_phase != 2) m_cnt <= 0;
            end
            case (m_phase)
                0: if (m_ps && !start_n) m_phase <= 1;
                1: begin m_phase <= 2; m_level <= '0; end
                2: begin
                    if (!go_n) m_phase <= 0;
                    else if (m_pl && !lvl_n && int'(m_level) < MAXL) m_phase <= 3;
                end
                default: begin m_phase <= 2; m_level <= m_level + 1'b1; end
            endcase
        end
    end

    always @(negedge clk) begin
        check("state", 32'(state), 32'(m_phase));
        check("t0", 32'(t0_n), 32'(m_phase != 1));
        check("upcount", 32'(up_n), 32'(m_phase != 3));
        check("tick", 32'(tick), 32'(m_tick));
        check("maxlevel", 32'(maxlvl), 32'(m_max));
        check("level", 32'(lvl_cnt), 32'(m_level));
        if (!up_n) n_up++;
        if (tick)  n_tick++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_n = 1'b0; cyc(1); start_n = 1'b1; cyc(2);
    endtask

    task automatic pulse_lvl();
        lvl_n = 1'b0; cyc(1); lvl_n = 1'b1; cyc(3);
    endtask

    task automatic pulse_go();
        go_n = 1'b0; cyc(1); go_n = 1'b1; cyc(1);
    endtask

    task automatic wait_tick(output int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 200);
        check("tick_seen", 32'(tick), 32'd1);
        c = cycle;
    endtask

    task automatic check_period(input string tag, input int exp);
        int ta, tb;
        wait_tick(ta);
        wait_tick(tb);
        check(tag, 32'(tb - ta), 32'(exp));
    endtask

    initial begin
        int ups0, ticks0, ta, tb;
        cyc(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_upcount", 32'(up_n), 32'd1);
        check("rst_t0", 32'(t0_n), 32'd1);
        check("rst_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        cyc(2);

        // 1: start -> one-cycle CLEAR, level 0, period 10
        start_n = 1'b0; cyc(1); start_n = 1'b1;
        check("clear_state", 32'(state), 32'd1);
        check("clear_t0", 32'(t0_n), 32'd0);
        cyc(1);
        check("run_state", 32'(state), 32'd2);
        check("run_t0", 32'(t0_n), 32'd1);
        check("run_level", 32'(lvl_cnt), 32'd0);
        check_period("period_l0", 10);

        // 2: held levelup -> single strobe, period 8
        ups0 = n_up;
        lvl_n = 1'b0; cyc(20); lvl_n = 1'b1; cyc(2);
        check("held_ups", 32'(n_up - ups0), 32'd1);
        check("held_level", 32'(lvl_cnt), 32'd1);
        check_period("period_l1", 8);

        // 3: four pulses from level 0 -> three strobes, clamp to 5
        pulse_go(); pulse_start();
        ups0 = n_up;
        repeat (4) pulse_lvl();
        check("sat_ups", 32'(n_up - ups0), 32'd3);
        check("sat_level", 32'(lvl_cnt), 32'd3);
        check("sat_max", 32'(maxlvl), 32'd1);
        check_period("period_clamp", 5);

        // 4: hold stretches one period; gameover beats levelup
        pulse_go(); pulse_start();
        wait_tick(ta);
        cyc(3); hold_n = 1'b0; cyc(7); hold_n = 1'b1;
        wait_tick(tb);
        check("hold_period", 32'(tb - ta), 32'd17);
        ups0 = n_up;
        go_n = 1'b0; lvl_n = 1'b0; cyc(1); go_n = 1'b1; cyc(2); lvl_n = 1'b1;
        check("go_state", 32'(state), 32'd0);
        ticks0 = n_tick;
        cyc(30);
        check("go_ups", 32'(n_up - ups0), 32'd0);
        check("go_ticks", 32'(n_tick - ticks0), 32'd0);

        // 5: reset during LEVELUP; reset glitch between edges
        pulse_start();
        lvl_n = 1'b0; cyc(1);
        check("lu_state", 32'(state), 32'd3);
        rst = 1'b1; cyc(1);
        check("lu_rst_state", 32'(state), 32'd0);
        check("lu_rst_up", 32'(up_n), 32'd1);
        check("lu_rst_tick", 32'(tick), 32'd0);
        rst = 1'b0; lvl_n = 1'b1; cyc(2);
        pulse_start();
        #2 rst = 1'b1; #2 rst = 1'b0;
        cyc(1);
        check("glitch_state", 32'(state), 32'd2);

        // 6: level 2, gameover, restart -> back to level 0
        pulse_lvl(); pulse_lvl();
        check("l2_level", 32'(lvl_cnt), 32'd2);
        pulse_go(); pulse_start();
        check("restart_level", 32'(lvl_cnt), 32'd0);
        check("restart_max", 32'(maxlvl), 32'd0);
        check_period("period_restart", 10);

        for (int i = 0; i < 1500; i++) begin
            start_n = ($urandom_range(0, 15) != 0);
            lvl_n   = ($urandom_range(0, 5) != 0);
            go_n    = ($urandom_range(0, 60) != 0);
            hold_n  = ($urandom_range(0, 7) != 0);
            rst     = ($urandom_range(0, 300) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
